// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the fetch stage.
//  - NOP_INSTR: canonical addi x0,x0,0 encoding
//  - a few base opcodes and the rs1/rs2 field positions
//  - fetch FSM state type
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[RS1_LSB +: 5];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[RS2_LSB +: 5];
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// Synchronous FIFO used as the prefetch queue storage.
// Ports:
//  clk, rst_n       clock, async active-low reset (pointers only)
//  i_push/i_pop     enqueue / dequeue (ignored when full / empty)
//  i_flush          empties the queue; overrides push and pop
//  i_wdata/o_rdata  entry in / head entry out (head valid when !o_empty)
//  o_level          occupancy, o_full / o_empty status
module pq_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_push;
    logic         w_pop;

    // Pointers carry one extra wrap bit: equal low bits with differing
    // MSB means the write side has lapped the read side (full).
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_level = r_wr - r_rd;
    assign o_rdata = r_mem[r_rd[AW-1:0]];

    assign w_push = i_push & ~o_full  & ~i_flush;
    assign w_pop  = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue between the
// instruction bus and decode. Fetching continues while decode stalls.
// Ports:
//  clk, rst                      clock, async active-low reset
//  iaddr/ireq/idata/iready_n     instruction bus (same-cycle response)
//  redir_early(_pc)              ID-stage redirect
//  redir_late(_pc)               MEM-stage redirect, wins over early
//  out_ready/out_valid           decode handshake on the queue head
//  out_instr/out_pc/out_pcp4     head entry (NOP / zero when empty)
//  out_rs1/out_rs2               head register fields for hazard unit
//  level                         queue occupancy
module fetch_prefetch_queue
    import rv32_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iready_n,
    input  logic [XLEN-1:0]          idata,
    output logic [XLEN-1:0]          iaddr,
    output logic                     ireq,
    input  logic                     redir_early,
    input  logic [XLEN-1:0]          redir_early_pc,
    input  logic                     redir_late,
    input  logic [XLEN-1:0]          redir_late_pc,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pcp4,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + XLEN;

    fetch_state_e   r_state;
    fetch_state_e   w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;

    logic            w_redir;
    logic [XLEN-1:0] w_target;
    logic            w_fire;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [EW-1:0]   w_head;
    logic [LW-1:0]   w_level;

    assign w_redir  = redir_early | redir_late;
    assign w_target = (redir_late ? redir_late_pc : redir_early_pc) & ~XLEN'(3);

    // ireq is gated by rst so the bus stays idle while reset is held.
    assign ireq   = rst & ~w_full & ~w_redir;
    assign iaddr  = r_fetch_pc;
    assign w_fire = ireq & ~iready_n;
    assign w_pop  = ~w_empty & out_ready & ~w_redir;

    pq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_fire),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_wdata ({idata[31:0], r_fetch_pc}),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= XLEN'(RESET_PC);
            r_state    <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
            if (w_redir)     r_fetch_pc <= w_target;
            else if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
    end

    // Fetch behaviour is identical in RUN/WAIT/FLUSH; the state tracks
    // bus wait states and the post-redirect cycle for observability.
    always_comb begin
        w_state_nxt = r_state;
        if (w_redir) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            unique case (r_state)
                ST_FLUSH: w_state_nxt = ST_RUN;
                ST_RUN:   if (ireq && iready_n) w_state_nxt = ST_WAIT;
                ST_WAIT:  if (!iready_n)        w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign out_valid = ~w_empty;
    assign out_instr = out_valid ? w_head[EW-1 -: 32] : NOP_INSTR;
    assign out_pc    = out_valid ? w_head[XLEN-1:0] : '0;
    assign out_pcp4  = out_valid ? w_head[XLEN-1:0] + XLEN'(4) : '0;
    assign out_rs1   = rs1_of(out_instr);
    assign out_rs2   = rs2_of(out_instr);
    assign level     = w_level;

endmodule
